act_rf_ni_read_ctrl: RTL and testbench

- Network-interface-side initiator for output-activation readout from the PE activation register file.
- On a start command it walks a contiguous address range and raises ni_read_rqst/ni_read_addr into the output-activation read mux.
- The mux always gives the ADD computation (comp_en_add) priority; this block treats those cycles as stalls.
- Returned read data is buffered in a small FIFO and streamed to the NI packetizer over a valid/ready interface.

---
 rtl/act_rf_ni_read_ctrl_if.sv | 26 ++
 rtl/act_rf_ni_read_ctrl.sv | 81 ++++++++
 tb/tb_act_rf_ni_read_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/act_rf_ni_read_ctrl_if.sv
// act_rf_ni_read_ctrl_if: command, RF read-port and output-stream signals of the NI activation reader
interface act_rf_ni_read_ctrl_if #(
   parameter int ACT_ADDR_W = 6,
   parameter int ACT_DATA_W = 16
);
   logic                  start;
   logic [ACT_ADDR_W-1:0] start_addr;
   logic [ACT_ADDR_W:0]   read_len;
   logic                  comp_en_add;
   logic                  ni_read_rqst;
   logic [ACT_ADDR_W-1:0] ni_read_addr;
   logic [ACT_DATA_W-1:0] rf_read_data;
   logic                  out_valid;
   logic [ACT_DATA_W-1:0] out_data;
   logic                  out_ready;
   logic                  busy;
   logic                  done;
   modport master (
      output start, start_addr, read_len, comp_en_add, rf_read_data, out_ready,
      input  ni_read_rqst, ni_read_addr, out_valid, out_data, busy, done
   );
   modport slave (
      input  start, start_addr, read_len, comp_en_add, rf_read_data, out_ready,
      output ni_read_rqst, ni_read_addr, out_valid, out_data, busy, done
   );
endinterface

// File: rtl/act_rf_ni_read_ctrl.sv
// act_rf_ni_read_ctrl: walks an activation address range through a stall-prone read port into a credit-limited output FIFO
module act_rf_ni_read_ctrl #(
   parameter int ACT_ADDR_W = 6,
   parameter int ACT_DATA_W = 16,
   parameter int FIFO_DEPTH = 2
) (
   input logic                  clk,
   input logic                  rst,
   act_rf_ni_read_ctrl_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [ACT_ADDR_W:0] MAX_LEN = {1'b1, {ACT_ADDR_W{1'b0}}};
   localparam logic [ACT_ADDR_W:0] ONE_LEFT = {{ACT_ADDR_W{1'b0}}, 1'b1};
   localparam logic [PW:0] DEPTH = (PW+1)'(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
   state_t                r_state;
   logic [ACT_ADDR_W-1:0] r_addr;
   logic [ACT_ADDR_W:0]   r_rem;
   logic                  r_inflight;
   logic                  r_busy;
   logic                  r_done;
   logic [ACT_DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wp;
   logic [PW-1:0]         r_rp;
   logic [PW:0]           r_cnt;
   logic                  w_rqst;
   logic                  w_grant;
   logic                  w_pop;
   logic [PW:0]           w_cnt_nxt;
   // an in-flight read holds a FIFO credit so the push one cycle later always fits
   assign w_rqst    = (r_state == READ) && (r_rem != '0) && ((r_cnt + (PW+1)'(r_inflight)) < DEPTH);
   assign w_grant   = w_rqst && !bus.comp_en_add;
   assign w_pop     = (r_cnt != '0) && bus.out_ready;
   assign w_cnt_nxt = r_cnt + (PW+1)'(r_inflight) - (PW+1)'(w_pop);
   assign bus.ni_read_rqst = w_rqst;
   assign bus.ni_read_addr = w_rqst ? r_addr : '0;
   assign bus.out_valid    = r_cnt != '0;
   assign bus.out_data     = (r_cnt != '0) ? r_mem[r_rp] : '0;
   assign bus.busy         = r_busy;
   assign bus.done         = r_done;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_addr     <= '0;
         r_rem      <= '0;
         r_inflight <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_cnt      <= '0;
      end else begin
         r_inflight <= w_grant;
         r_cnt      <= w_cnt_nxt;
         r_done     <= 1'b0;
         if (r_inflight) begin
            r_mem[r_wp] <= bus.rf_read_data;
            r_wp        <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         if (w_grant) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
         end
         if (r_state == IDLE && bus.start) begin
            if (bus.read_len == '0) r_done <= 1'b1;
            else begin
               r_state <= READ;
               r_busy  <= 1'b1;
               r_addr  <= bus.start_addr;
               r_rem   <= (bus.read_len > MAX_LEN) ? MAX_LEN : bus.read_len;
            end
         end else if (r_state == READ && w_grant && r_rem == ONE_LEFT) r_state <= DRAIN;
         else if (r_state == DRAIN && !r_inflight && w_cnt_nxt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_act_rf_ni_read_ctrl.sv
// tb_act_rf_ni_read_ctrl: queue-based reference model compared every cycle, plus literal scenario checks
module tb_act_rf_ni_read_ctrl;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;
   act_rf_ni_read_ctrl_if bus ();
   act_rf_ni_read_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
   logic [15:0] mem [64];
   int total = 0;
   int bad = 0;
   bit chk_en = 0;
   bit rnd_mode = 0;
   always @(posedge clk) bus.rf_read_data <= mem[bus.ni_read_addr];
   always @(posedge clk) if (rnd_mode) begin
      #2;
      bus.comp_en_add = ($urandom_range(0, 3) == 0);
      bus.out_ready   = ($urandom_range(0, 3) != 0);
   end
   bit          m_active, m_infl, m_done;
   int          m_infl_addr;
   int          q_todo[$];
   logic [15:0] q_fifo[$];
   function automatic bit m_rqst();
      return m_active && q_todo.size() > 0 && (q_fifo.size() + int'(m_infl)) < 2;
   endfunction
   always @(posedge clk) begin
      if (rst) begin
         m_active = 0; m_infl = 0; m_done = 0;
         q_todo.delete(); q_fifo.delete();
      end else begin
         automatic bit g = m_rqst() && !bus.comp_en_add;
         automatic bit p = q_fifo.size() > 0 && bus.out_ready;
         automatic int len;
         if (p) void'(q_fifo.pop_front());
         if (m_infl) q_fifo.push_back(mem[m_infl_addr]);
         m_infl = g;
         if (g) m_infl_addr = q_todo.pop_front();
         m_done = 0;
         if (!m_active && bus.start) begin
            len = (int'(bus.read_len) > 64) ? 64 : int'(bus.read_len);
            if (len == 0) m_done = 1;
            else begin
               m_active = 1;
               for (int i = 0; i < len; i++) q_todo.push_back((int'(bus.start_addr) + i) % 64);
            end
         end else if (m_active && q_todo.size() == 0 && !m_infl && q_fifo.size() == 0) begin
            m_active = 0;
            m_done = 1;
         end
      end
   end
   int cyc = 0;
   int grants[$];
   int words[$];
   int first_rqst, first_valid, last_hand, done_cyc, stall5;
   bit done_seen, rqst_seen, busy_seen;
   always @(negedge clk) if (chk_en) begin
      automatic bit e_rqst = m_rqst();
      automatic int e_addr = e_rqst ? q_todo[0] : 0;
      automatic bit e_valid = q_fifo.size() > 0;
      automatic int e_data = e_valid ? int'(q_fifo[0]) : 0;
      cyc++;
      total++;
      if (bus.ni_read_rqst !== e_rqst || int'(bus.ni_read_addr) != e_addr || bus.out_valid !== e_valid ||
          int'(bus.out_data) != e_data || bus.busy !== m_active || bus.done !== m_done) begin
         bad++;
         $display("FAIL model cyc=%0d got rqst=%0b addr=%0d valid=%0b data=%0d busy=%0b done=%0b expected rqst=%0b addr=%0d valid=%0b data=%0d busy=%0b done=%0b",
                  cyc, bus.ni_read_rqst, bus.ni_read_addr, bus.out_valid, bus.out_data, bus.busy, bus.done,
                  e_rqst, e_addr, e_valid, e_data, m_active, m_done);
      end
      if (bus.ni_read_rqst && !bus.comp_en_add) grants.push_back(int'(bus.ni_read_addr));
      if (bus.ni_read_rqst && bus.comp_en_add && bus.ni_read_addr == 6'd5) stall5++;
      if (bus.ni_read_rqst && first_rqst < 0) first_rqst = cyc;
      if (bus.out_valid && first_valid < 0) first_valid = cyc;
      if (bus.out_valid && bus.out_ready) begin
         words.push_back(int'(bus.out_data));
         last_hand = cyc;
      end
      if (bus.done) begin
         done_seen = 1;
         done_cyc = cyc;
      end
      if (bus.ni_read_rqst) rqst_seen = 1;
      if (bus.busy) busy_seen = 1;
   end
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #2;
   endtask
   task automatic clr();
      grants.delete(); words.delete();
      first_rqst = -1; first_valid = -1; last_hand = -1; done_cyc = -1; stall5 = 0;
      done_seen = 0; rqst_seen = 0; busy_seen = 0;
   endtask
   task automatic issue(input int a, input int l);
      bus.start = 1'b1;
      bus.start_addr = 6'(a);
      bus.read_len = 7'(l);
      tick();
      bus.start = 1'b0;
   endtask
   task automatic wait_done(input string name, input int budget);
      for (int i = 0; i < budget && !done_seen; i++) tick();
      chk({name, "_done"}, int'(done_seen), 1);
   endtask
   task automatic chk_words(input string name, input int a, input int n);
      chk({name, "_nwords"}, words.size(), n);
      for (int i = 0; i < n; i++) chk($sformatf("%s_word%0d", name, i), words[i], int'(mem[(a + i) % 64]));
   endtask
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'(i * 3);
      rst = 1'b1;
      bus.start = 1'b0; bus.start_addr = '0; bus.read_len = '0;
      bus.comp_en_add = 1'b0; bus.out_ready = 1'b1; bus.rf_read_data = '0;
      clr();
      tick();
      chk_en = 1;
      tick(); tick();
      rst = 1'b0;
      tick();
      // basic 4-word read
      clr();
      issue(4, 4);
      wait_done("s1", 40);
      chk("s1_ngrants", grants.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("s1_grant%0d", i), grants[i], 4 + i);
      chk("s1_w0", words[0], 12);
      chk("s1_w3", words[3], 21);
      chk_words("s1", 4, 4);
      chk("s1_first_latency", first_valid - first_rqst, 2);
      chk("s1_done_after_hand", done_cyc - last_hand, 1);
      tick();
      // ADD stalls on address 5
      clr();
      issue(4, 4);
      tick();
      bus.comp_en_add = 1'b1;
      repeat (3) tick();
      bus.comp_en_add = 1'b0;
      wait_done("s2", 40);
      chk("s2_stall5", stall5, 3);
      chk("s2_ngrants", grants.size(), 4);
      chk_words("s2", 4, 4);
      tick();
      // backpressure
      clr();
      bus.out_ready = 1'b0;
      issue(10, 6);
      repeat (9) tick();
      chk("s3_grants_blocked", grants.size(), 2);
      chk("s3_rqst_low", int'(bus.ni_read_rqst), 0);
      chk("s3_head", int'(bus.out_data), 30);
      bus.out_ready = 1'b1;
      wait_done("s3", 40);
      chk_words("s3", 10, 6);
      tick();
      // address wrap
      clr();
      issue(62, 4);
      wait_done("s4", 40);
      chk("s4_g0", grants[0], 62);
      chk("s4_g1", grants[1], 63);
      chk("s4_g2", grants[2], 0);
      chk("s4_g3", grants[3], 1);
      tick();
      // zero-length command
      clr();
      issue(7, 0);
      repeat (3) tick();
      chk("s5_done", int'(done_seen), 1);
      chk("s5_no_rqst", int'(rqst_seen), 0);
      chk("s5_no_busy", int'(busy_seen), 0);
      // reset mid-command
      clr();
      issue(20, 8);
      for (int i = 0; i < 20 && grants.size() < 2; i++) tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      chk("s6_rst_rqst", int'(bus.ni_read_rqst), 0);
      chk("s6_rst_valid", int'(bus.out_valid), 0);
      chk("s6_rst_data", int'(bus.out_data), 0);
      chk("s6_rst_busy", int'(bus.busy), 0);
      rst = 1'b0;
      repeat (3) tick();
      chk("s6_no_done", int'(done_seen), 0);
      clr();
      issue(0, 1);
      wait_done("s6b", 20);
      chk("s6b_ngrants", grants.size(), 1);
      chk_words("s6b", 0, 1);
      tick();
      // oversize length clamps to full range, with random stalls and backpressure
      rnd_mode = 1;
      clr();
      issue(5, 100);
      wait_done("s7", 800);
      chk_words("s7", 5, 64);
      tick();
      // random commands, including an ignored start while busy
      for (int k = 0; k < 15; k++) begin
         automatic int a = $urandom_range(0, 63);
         automatic int l = $urandom_range(0, 64);
         clr();
         issue(a, l);
         if (l > 0) begin
            tick();
            issue($urandom_range(0, 63), $urandom_range(1, 64));
         end
         wait_done($sformatf("r%0d", k), 900);
         if (l > 0) chk_words($sformatf("r%0d", k), a, l);
         tick();
      end
      rnd_mode = 0;
      repeat (2) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
